// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU-driven multiply/divide sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SH_HOLD = 2'd0,
        SH_LOAD = 2'd1,
        SH_SHR  = 2'd2,
        SH_SHL  = 2'd3
    } sh_mode_e;

    localparam logic [2:0] ALU_OP_ADDSUB = 3'b000;
    localparam logic       ALU_CTRL_ADD  = 1'b0;
    localparam logic       ALU_CTRL_SUB  = 1'b1;
    localparam logic       OP_MUL        = 1'b0;
    localparam logic       OP_DIV        = 1'b1;

endpackage

// File: rtl/alu_seq_shreg.sv
// 64-bit hi/lo working register: parallel load, multiply right-shift with
// carry-in, divide left-shift with new remainder and quotient bit.
module alu_seq_shreg
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  sh_mode_e    mode,
    input  logic [31:0] ld_hi,
    input  logic [31:0] ld_lo,
    input  logic        carry,
    input  logic [31:0] sum,
    input  logic [31:0] new_rem,
    input  logic        qbit,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Working register update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= 32'h0000_0000;
            lo <= 32'h0000_0000;
        end else begin
            case (mode)
                SH_LOAD: begin
                    hi <= ld_hi;
                    lo <= ld_lo;
                end
                SH_SHR: begin
                    hi <= {carry, sum[31:1]};
                    lo <= {sum[0], lo[31:1]};
                end
                SH_SHL: begin
                    hi <= new_rem;
                    lo <= {lo[30:0], qbit};
                end
                default: begin
                    hi <= hi;
                    lo <= lo;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 32x32 multiply / 32/32 restoring divide driving an external ALU.
// Divide support is compiled in when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv_seq
    import alu_seq_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_err,
    output logic        alu_en,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [2:0]  alu_opcode,
    output logic        alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_carry
);

    state_e      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [31:0] a_r, a_s;
`ifdef ALU_MULDIV_DIV_EN
    logic [31:0] b_r, b_s;
`endif
    logic        err_r, err_s;
    sh_mode_e    sh_mode_s;
    logic [31:0] ld_hi_s, ld_lo_s, new_rem_s;
    logic        qbit_s;
    logic [31:0] sh_hi_s, sh_lo_s;
    logic        last_s;

    assign last_s     = (cnt_r == 5'(ITERS - 1));
    assign alu_opcode = ALU_OP_ADDSUB;
    assign req_ready  = (state_r == IDLE);
    assign rsp_valid  = (state_r == DONE);
    assign rsp_hi     = (state_r == DONE) ? sh_hi_s : 32'h0000_0000;
    assign rsp_lo     = (state_r == DONE) ? sh_lo_s : 32'h0000_0000;
    assign rsp_err    = (state_r == DONE) ? err_r : 1'b0;

    alu_seq_shreg u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (sh_mode_s),
        .ld_hi   (ld_hi_s),
        .ld_lo   (ld_lo_s),
        .carry   (alu_carry),
        .sum     (alu_result),
        .new_rem (new_rem_s),
        .qbit    (qbit_s),
        .hi      (sh_hi_s),
        .lo      (sh_lo_s)
    );

    // Sequencer state, counter and latched operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            a_r     <= 32'h0000_0000;
`ifdef ALU_MULDIV_DIV_EN
            b_r     <= 32'h0000_0000;
`endif
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
`ifdef ALU_MULDIV_DIV_EN
            b_r     <= b_s;
`endif
            err_r   <= err_s;
        end
    end

    // Next state, working-register control and ALU operand muxing
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        a_s       = a_r;
`ifdef ALU_MULDIV_DIV_EN
        b_s       = b_r;
`endif
        err_s     = err_r;
        sh_mode_s = SH_HOLD;
        ld_hi_s   = 32'h0000_0000;
        ld_lo_s   = 32'h0000_0000;
        new_rem_s = 32'h0000_0000;
        qbit_s    = 1'b0;
        alu_en    = 1'b0;
        alu_srca  = 32'h0000_0000;
        alu_srcb  = 32'h0000_0000;
        alu_ctrl  = ALU_CTRL_ADD;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    a_s       = req_a;
                    cnt_s     = 5'd0;
                    err_s     = 1'b0;
                    sh_mode_s = SH_LOAD;
                    if (req_op == OP_MUL) begin
                        ld_lo_s = req_b;
                        state_s = MUL;
                    end else begin
`ifdef ALU_MULDIV_DIV_EN
                        b_s = req_b;
                        if (req_b == 32'h0000_0000) begin
                            err_s   = 1'b1;
                            ld_hi_s = req_a;
                            ld_lo_s = 32'hFFFF_FFFF;
                            state_s = DONE;
                        end else begin
                            ld_lo_s = req_a;
                            state_s = DIV;
                        end
`else
                        err_s   = 1'b1;
                        state_s = DONE;
`endif
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                alu_en    = 1'b1;
                alu_srca  = sh_hi_s;
                alu_srcb  = sh_lo_s[0] ? a_r : 32'h0000_0000;
                alu_ctrl  = ALU_CTRL_ADD;
                sh_mode_s = SH_SHR;
                cnt_s     = cnt_r + 5'd1;
                state_s   = last_s ? DONE : MUL;
            end
`ifdef ALU_MULDIV_DIV_EN
            DIV: begin
                // Bit shifted out of rem makes t >= 2^32 > b, so subtract regardless
                alu_en    = 1'b1;
                alu_srca  = {sh_hi_s[30:0], sh_lo_s[31]};
                alu_srcb  = b_r;
                alu_ctrl  = ALU_CTRL_SUB;
                qbit_s    = sh_hi_s[31] | alu_carry;
                new_rem_s = qbit_s ? alu_result : alu_srca;
                sh_mode_s = SH_SHL;
                cnt_s     = cnt_r + 5'd1;
                state_s   = last_s ? DONE : DIV;
            end
`endif
            DONE: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq; follows ALU_MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_hi, rsp_lo;
    logic        rsp_err;
    logic        alu_en;
    logic [31:0] alu_srca, alu_srcb;
    logic [2:0]  alu_opcode;
    logic        alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic [32:0] add33;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External 32-bit adder/subtractor
    assign add33      = {1'b0, alu_srca} + {1'b0, alu_srcb};
    assign alu_result = alu_ctrl ? (alu_srca - alu_srcb) : add33[31:0];
    assign alu_carry  = alu_ctrl ? (alu_srca >= alu_srcb) : add33[32];

    alu_muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .rsp_err    (rsp_err),
        .alu_en     (alu_en),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_opcode (alu_opcode),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic err, output int steps);
        logic [63:0] p;
        if (op == 1'b0) begin
            p     = 64'(a) * 64'(b);
            hi    = p[63:32];
            lo    = p[31:0];
            err   = 1'b0;
            steps = 32;
        end else begin
`ifdef ALU_MULDIV_DIV_EN
            if (b == 32'd0) begin
                hi = a; lo = 32'hFFFF_FFFF; err = 1'b1; steps = 0;
            end else begin
                hi = a % b; lo = a / b; err = 1'b0; steps = 32;
            end
`else
            hi = 32'd0; lo = 32'd0; err = 1'b1; steps = 0;
`endif
        end
    endfunction

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] e_hi, e_lo;
        logic        e_err;
        int          e_steps, n, en_cnt;
        model(op, a, b, e_hi, e_lo, e_err, e_steps);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_op = 1'($urandom); req_a = $urandom; req_b = $urandom;
        n = 1;
        en_cnt = 0;
        while (!rsp_valid && n < 100) begin
            if (alu_en) en_cnt++;
            else check_val("alu_idle_zero", {alu_srca, alu_srcb} | 64'(alu_ctrl), 64'd0);
            check_val("busy_not_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            n++;
        end
        check_val("latency", 64'(n), 64'(e_steps + 1));
        check_val("alu_en_cycles", 64'(en_cnt), 64'(e_steps));
        check_val("rsp_hi", 64'(rsp_hi), 64'(e_hi));
        check_val("rsp_lo", 64'(rsp_lo), 64'(e_lo));
        check_val("rsp_err", 64'(rsp_err), 64'(e_err));
        check_val("done_alu_off", {alu_srca, alu_srcb} | 64'(alu_en) | 64'(alu_opcode), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 64'(rsp_valid), 64'd1);
            check_val("hold_data", {rsp_hi, rsp_lo}, {e_hi, e_lo});
            check_val("hold_err", 64'(rsp_err), 64'(e_err));
            check_val("hold_not_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("post_rsp_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int n, en_cnt, seen;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = 32'd0; req_b = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_rsp", {31'd0, rsp_valid, rsp_hi} | 64'(rsp_lo) | 64'(rsp_err), 64'd0);
        check_val("rst_alu", {alu_srca, alu_srcb} | 64'(alu_en) | 64'(alu_ctrl) | 64'(alu_opcode), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd7, 32'd6, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(1'b1, 32'd100, 32'd7, 0);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(1'b1, 32'd5, 32'd0, 2);
        run_op(1'b0, 32'd7, 32'd6, 5);
        run_op(1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 1);

        for (int k = 0; k < 24; k++) begin
            logic        op;
            logic [31:0] a, b;
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = a;
                default: b = $urandom;
            endcase
            run_op(op, a, b, $urandom_range(0, 3));
        end

        // Reset at step 10 of a multiply
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'd1234; req_b = 32'd5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        en_cnt = 0;
        n = 0;
        while (en_cnt < 10 && n < 50) begin
            if (alu_en) en_cnt++;
            if (en_cnt < 10) @(negedge clk);
            n++;
        end
        check_val("mid_steps", 64'(en_cnt), 64'd10);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mid_rst_ready", 64'(req_ready), 64'd1);
        check_val("mid_rst_alu_en", 64'(alu_en), 64'd0);
        check_val("mid_rst_valid", 64'(rsp_valid), 64'd0);
        seen = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || alu_en) seen++;
        end
        rsp_ready = 1'b0;
        check_val("mid_rst_no_rsp", 64'(seen), 64'd0);

        run_op(1'b0, 32'd3, 32'd9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
